// File: rtl/apu_pkg.sv
// Shared definitions for the audio processing unit: volume encoding, mixer
// state encoding and small elaboration-time helpers.
package apu_pkg;

  localparam int VOL_WIDTH = 5;
  localparam int VOL_UNITY = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SCALE
  } mix_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Volume codes above unity are treated as unity so 16 is the gain ceiling.
  function automatic logic [VOL_WIDTH-1:0] clamp_vol(input logic [VOL_WIDTH-1:0] v);
    return (v > VOL_WIDTH'(VOL_UNITY)) ? VOL_WIDTH'(VOL_UNITY) : v;
  endfunction

endpackage

// File: rtl/apu_mixer_if.sv
// Sample-strobe, channel and status bundle between the channel generators,
// the mixer and the DAC/PWM sink.
interface apu_mixer_if #(
  parameter int NUM_CH    = 4,
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 11
) ();

  logic                                   i_sample_stb;
  logic [NUM_CH*IN_WIDTH-1:0]             i_channels;
  logic [NUM_CH-1:0]                      i_enable;
  logic [NUM_CH*apu_pkg::VOL_WIDTH-1:0]   i_volume;
  logic [apu_pkg::VOL_WIDTH-1:0]          i_master;
  logic [OUT_WIDTH-1:0]                   o_sample;
  logic                                   o_valid;
  logic                                   o_clip;
  logic                                   o_busy;
  logic                                   o_overrun;

  modport master (
    output i_sample_stb, i_channels, i_enable, i_volume, i_master,
    input  o_sample, o_valid, o_clip, o_busy, o_overrun
  );

  modport slave (
    input  i_sample_stb, i_channels, i_enable, i_volume, i_master,
    output o_sample, o_valid, o_clip, o_busy, o_overrun
  );

endinterface

// File: rtl/apu_scale_sat.sv
// Combinational gain stage: clamp the volume, multiply, drop 8 fractional
// bits (truncating) and saturate to the output width with a clip flag.
module apu_scale_sat
  import apu_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int OUT_WIDTH = 11
) (
  input  logic [ACC_W-1:0]     acc,
  input  logic [VOL_WIDTH-1:0] vol,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 clip
);

  localparam int PROD_W = ACC_W + VOL_WIDTH;
  localparam int CMP_W  = (PROD_W > OUT_WIDTH) ? PROD_W : OUT_WIDTH + 1;

  logic [PROD_W-1:0] prod;
  logic [CMP_W-1:0]  shifted;
  logic [CMP_W-1:0]  limit;

  assign prod    = PROD_W'(acc) * PROD_W'(clamp_vol(vol));
  assign shifted = CMP_W'(prod >> 8);
  assign limit   = CMP_W'({OUT_WIDTH{1'b1}});
  assign clip    = (shifted > limit);
  assign result  = clip ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];

endmodule

// File: rtl/apu_mixer.sv
// Time-multiplexed channel mixer: one multiply-accumulate per channel per
// cycle, then a saturating master-volume stage feeding the sample sink.
module apu_mixer
  import apu_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 11
) (
  input  logic       i_clk,
  input  logic       i_rst,
  apu_mixer_if.slave bus
);

  // Wide enough for NUM_CH full-scale samples at unity gain, so no wrap.
  localparam int ACC_W = IN_WIDTH + VOL_WIDTH + clog2(NUM_CH);
  localparam int IDX_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mix_state_e state, state_next;

  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     term;
  logic [IN_WIDTH-1:0]  ch_q  [NUM_CH];
  logic [VOL_WIDTH-1:0] vol_q [NUM_CH];
  logic [NUM_CH-1:0]    en_q;
  logic [VOL_WIDTH-1:0] master_q;

  logic [OUT_WIDTH-1:0] sat_sample;
  logic                 sat_clip;
  logic [OUT_WIDTH-1:0] sample_q;
  logic                 valid_q;
  logic                 clip_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (bus.i_sample_stb) state_next = ST_ACCUM;
      ST_ACCUM: if (idx == LAST_IDX)  state_next = ST_SCALE;
      ST_SCALE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    term = '0;
    if (en_q[idx])
      term = ACC_W'(ch_q[idx]) * ACC_W'(clamp_vol(vol_q[idx]));
  end

  apu_scale_sat #(
    .ACC_W    (ACC_W),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_scale (
    .acc   (acc),
    .vol   (master_q),
    .result(sat_sample),
    .clip  (sat_clip)
  );

  // Inputs are captured only on an accepted strobe; the mix then runs purely
  // from the snapshot so the generators may move on immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      idx      <= '0;
      acc      <= '0;
      en_q     <= '0;
      master_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i]  <= '0;
        vol_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.i_sample_stb) begin
            acc      <= '0;
            idx      <= '0;
            en_q     <= bus.i_enable;
            master_q <= bus.i_master;
            for (int i = 0; i < NUM_CH; i++) begin
              ch_q[i]  <= bus.i_channels[i*IN_WIDTH +: IN_WIDTH];
              vol_q[i] <= bus.i_volume[i*VOL_WIDTH +: VOL_WIDTH];
            end
          end
        end
        ST_ACCUM: begin
          acc <= acc + term;
          idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        ST_SCALE: begin
          sample_q <= sat_sample;
          clip_q   <= sat_clip;
          valid_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_sample  = sample_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_clip    = clip_q;
  assign bus.o_busy    = (state != ST_IDLE);
  assign bus.o_overrun = bus.i_sample_stb && (state != ST_IDLE);

endmodule

// File: tb/tb_apu_mixer.sv
// Scoreboard bench for apu_mixer (4 channels, 9-bit in, 10-bit out so that
// saturation is reachable) against an arithmetic reference of the mix rules.
module tb_apu_mixer;

  localparam int NCH  = 4;
  localparam int INW  = 9;
  localparam int OUTW = 10;

  typedef struct {
    logic [OUTW-1:0] sample;
    logic            clip;
    int              due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [OUTW-1:0] last_sample = '0;
  logic            last_clip   = 1'b0;

  apu_mixer_if #(.NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW)) bus ();

  apu_mixer #(.NUM_CH(NCH), .IN_WIDTH(INW), .OUT_WIDTH(OUTW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void refMix(input logic [NCH*INW-1:0] chs, input logic [NCH-1:0] en,
                                 input logic [NCH*5-1:0] vols, input logic [4:0] m,
                                 output logic [OUTW-1:0] s, output logic c);
    int sum, v, r;
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        v = int'(vols[i*5 +: 5]);
        if (v > 16) v = 16;
        sum += int'(chs[i*INW +: INW]) * v;
      end
    end
    v = int'(m);
    if (v > 16) v = 16;
    r = (sum * v) / 256;
    if (r > (1 << OUTW) - 1) begin
      s = '1;
      c = 1'b1;
    end else begin
      s = OUTW'(r);
      c = 1'b0;
    end
  endfunction

  // Called at a negedge while the mixer is idle; returns one cycle later.
  task automatic applyStimulus(input logic [NCH*INW-1:0] chs, input logic [NCH-1:0] en,
                               input logic [NCH*5-1:0] vols, input logic [4:0] m);
    exp_t e;
    bus.i_channels   = chs;
    bus.i_enable     = en;
    bus.i_volume     = vols;
    bus.i_master     = m;
    bus.i_sample_stb = 1'b1;
    refMix(chs, en, vols, m, e.sample, e.clip);
    e.due = cyc + 6;
    sb.push_back(e);
    #1;
    checkOutput("overrun_when_idle", int'(bus.o_overrun), 0);
    @(negedge clk);
    bus.i_sample_stb = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 30 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: pops the scoreboard on every o_valid, checks the outputs hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_sample = '0;
      last_clip   = 1'b0;
    end else if (bus.o_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sample", int'(bus.o_sample), int'(e.sample));
        checkOutput("clip", int'(bus.o_clip), int'(e.clip));
        checkOutput("latency", cyc, e.due);
        last_sample = e.sample;
        last_clip   = e.clip;
      end
    end else begin
      checkOutput("sample_hold", int'(bus.o_sample), int'(last_sample));
      checkOutput("clip_hold", int'(bus.o_clip), int'(last_clip));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NCH*INW-1:0] chs;
    logic [NCH*5-1:0]   vols;
    int gap;

    bus.i_sample_stb = 1'b0;
    bus.i_channels   = '0;
    bus.i_enable     = '0;
    bus.i_volume     = '0;
    bus.i_master     = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_sample", int'(bus.o_sample), 0);
    checkOutput("rst_valid", int'(bus.o_valid), 0);
    checkOutput("rst_clip", int'(bus.o_clip), 0);
    checkOutput("rst_busy", int'(bus.o_busy), 0);
    checkOutput("rst_overrun", int'(bus.o_overrun), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    $display("[TB] unity mix with busy window");
    chs  = {9'd400, 9'd300, 9'd200, 9'd100};
    vols = {4{5'd16}};
    applyStimulus(chs, 4'b1111, vols, 5'd16);
    for (int k = 1; k <= 5; k++) begin
      checkOutput("busy_during_mix", int'(bus.o_busy), 1);
      @(negedge clk);
    end
    checkOutput("busy_after_mix", int'(bus.o_busy), 0);
    waitDrain();

    $display("[TB] enable mask and master volume");
    applyStimulus(chs, 4'b0101, vols, 5'd8);
    waitDrain();

    $display("[TB] volume clamp and silence");
    chs  = {9'd77, 9'd88, 9'd99, 9'd256};
    vols = {5'd3, 5'd20, 5'd9, 5'd31};
    applyStimulus(chs, 4'b0001, vols, 5'd16);
    waitDrain();
    applyStimulus(chs, 4'b0001, vols, 5'd0);
    waitDrain();
    applyStimulus(chs, 4'b1111, {4{5'd16}}, 5'd25);
    waitDrain();

    $display("[TB] saturation then recovery");
    applyStimulus({4{9'd511}}, 4'b1111, {4{5'd16}}, 5'd16);
    waitDrain();
    applyStimulus('0, 4'b1111, {4{5'd16}}, 5'd16);
    waitDrain();

    $display("[TB] overrun and input snapshot");
    applyStimulus({9'd10, 9'd20, 9'd30, 9'd40}, 4'b1111, {4{5'd12}}, 5'd16);
    bus.i_channels = NCH*INW'($urandom);
    bus.i_volume   = NCH*5'($urandom);
    @(negedge clk);
    bus.i_sample_stb = 1'b1;
    #1;
    checkOutput("overrun_pulse", int'(bus.o_overrun), 1);
    @(negedge clk);
    bus.i_sample_stb = 1'b0;
    #1;
    checkOutput("overrun_clear", int'(bus.o_overrun), 0);
    waitDrain();

    $display("[TB] reset during a mix");
    applyStimulus({9'd1, 9'd2, 9'd3, 9'd4}, 4'b1111, {4{5'd16}}, 5'd16);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_busy", int'(bus.o_busy), 0);
    checkOutput("midrst_valid", int'(bus.o_valid), 0);
    checkOutput("midrst_sample", int'(bus.o_sample), 0);
    checkOutput("midrst_clip", int'(bus.o_clip), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    applyStimulus({9'd500, 9'd400, 9'd300, 9'd200}, 4'b1110, {5'd16, 5'd8, 5'd4, 5'd2}, 5'd16);
    waitDrain();

    $display("[TB] randomized mixes, including back-to-back strobes");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NCH; i++) begin
        chs[i*INW +: INW] = (n % 5 == 0) ? INW'(511 - $urandom_range(0, 3))
                                          : INW'($urandom_range(0, 511));
        vols[i*5 +: 5]    = 5'($urandom_range(0, 31));
      end
      applyStimulus(chs, NCH'($urandom), vols, 5'($urandom_range(0, 31)));
      gap = $urandom_range(5, 7);
      repeat (gap) @(negedge clk);
    end
    waitDrain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apu_mixer.md
Name: apu_mixer

Overview:
- Parametrised successor to the fixed 4-channel additive mixer in the audio processing unit.
- Mixes NUM_CH unsigned channel samples with per-channel enable, per-channel 5-bit volume and a master volume.
- Uses a time-multiplexed multiply-accumulate, one channel per cycle, then saturates to OUT_WIDTH.
- Sits between the channel generators and the DAC/PWM sample sink; started by a sample-rate strobe.

Parameters:
NUM_CH, 4, number of input channels (>=1)
IN_WIDTH, 9, unsigned width of each channel sample
OUT_WIDTH, 11, unsigned width of the mixed output sample

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_sample_stb  input  1  single-cycle pulse that starts one mix
i_channels  input  NUM_CH*IN_WIDTH  channel samples, ch0 in LSBs
i_enable  input  NUM_CH  per-channel enable, 1 = mixed (generalises the old mixer mask)
i_volume  input  NUM_CH*5  per-channel volume 0..16, ch0 in LSBs
i_master  input  5  master volume 0..16
o_sample  output  OUT_WIDTH  mixed sample, held between updates
o_valid  output  1  one-cycle pulse when o_sample updates
o_clip  output  1  high with o_valid when the result saturated; held until the next o_valid
o_busy  output  1  high while a mix is in progress
o_overrun  output  1  one-cycle pulse when i_sample_stb arrives while busy

Behaviour:
- Reset (async, i_rst=1): o_sample=0, o_valid=0, o_clip=0, o_busy=0, o_overrun=0, state=IDLE, accumulator=0, index=0.
- Clock and reset are fixed: one clock i_clk; i_rst is asynchronous and active-high.
- States: IDLE, ACCUM, SCALE.
- IDLE + i_sample_stb (cycle 0):
  - Snapshot i_channels, i_enable, i_volume and i_master into registers.
  - Clear the accumulator, set index=0, go to ACCUM, o_busy=1 from cycle 1.
- ACCUM, one cycle per channel, index 0..NUM_CH-1:
  - acc += (enable[idx] ? sample[idx]*vol_eff[idx] : 0).
  - After the index NUM_CH-1 cycle, go to SCALE.
- SCALE:
  - r = (acc * master_eff) >> 8, truncated with no rounding.
  - If r > 2^OUT_WIDTH-1: o_sample=all ones and o_clip=1. Otherwise o_sample=r and o_clip=0.
  - Assert o_valid on the next cycle; return to IDLE; o_busy=0.
- Latency: strobe at cycle 0, o_valid high at cycle NUM_CH+2. Throughput is one mix per NUM_CH+2 cycles.
- Volume clamp: vol_eff = min(vol,16) and master_eff = min(master,16). 16 is unity, 0 is silence.
- Accumulator width: IN_WIDTH+5+clog2(NUM_CH), with no internal overflow. The scale product is 5 bits wider.
- Inputs may change freely after the strobe cycle; only the snapshot is used.
- Strobe while busy (including the cycle o_valid is high? no: o_valid is in IDLE):
  - The strobe is ignored and o_overrun pulses for that cycle.
  - The in-progress mix is unaffected.
- Strobe on the same cycle as o_valid: accepted, because the block is already IDLE. Back-to-back mixes are legal.
- Reset mid-mix: abort immediately and return to reset values. No o_valid is produced.
- NUM_CH=1: ACCUM lasts one cycle and the latency is 3.

Decomposition:
- Shared package apu_pkg holds:
  - VOL_WIDTH=5 and VOL_UNITY=16.
  - The mixer state encoding (IDLE/ACCUM/SCALE).
  - A clog2 helper function.
- One natural sub-module: apu_scale_sat. It is combinational: clamp the volume, multiply, shift, then saturate with a clip flag. It is used for the final master stage; the per-channel MAC reuses its clamp.

Test Plan:
- Unity mix: channels 100/200/300/400, enable 4'b1111, all vol 16, master 16, strobe -> o_valid exactly 6 cycles later with o_sample=1000, o_clip=0, o_busy high for cycles 1..5.
- Enable/master: same channels, enable 4'b0101, master 8 -> o_sample=200 ((100+300)*16*8>>8), o_clip=0.
- Clamp and silence: ch0=256, vol0=31 (treated as 16), other channels disabled, master 16 -> 256; same with master 0 -> 0.
- Saturation with OUT_WIDTH=10: all channels 511, vol 16, master 16 -> sum 2044 saturates, o_sample=1023, o_clip=1; the next mix of all zeros -> 0, o_clip=0.
- Overrun/snapshot: a second strobe at cycle 2 -> o_overrun pulse at cycle 2 and a single o_valid at cycle 6. Changing i_channels at cycle 1 does not alter the result.
- Reset mid-mix: assert i_rst asynchronously at cycle 3 -> outputs clear immediately and no o_valid. A strobe after release gives the correct result at +6 cycles.
